ram_pipe: RTL and testbench



---
 rtl/ram_pipe.sv | 117 +++++++++++
 tb/tb_ram_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_pipe.sv
// Single-port synchronous RAM with a valid/ready request port, byte-lane writes,
// an RD_LAT-deep read response pipeline and an optional post-reset zero-fill walk.
module ram_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;

  logic             accept;
  logic             rd_accept;
  logic             in_range;
  logic             clr_en;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;

  // NOTE: the array has no reset; only the INIT walk clears it, so it can map onto a RAM macro.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_wr;
  // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx       = req_addr[IDX_W-1:0];
  assign clr_en    = (INIT_CLEAR != 0) && (state_q == ST_INIT);
  assign rd_word   = in_range ? mem[idx] : '0;

  // NOTE: every flop is updated with <= so all registers sample the same pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == ST_INIT) begin
      if (INIT_CLEAR == 0 || clr_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        clr_d = clr_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr_en) begin
      mem[clr_q] <= '0;
    end else if (accept && req_wr && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Data/err stages only load behind a valid, so the output holds its last response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_accept;
      if (rd_accept) begin
        dat_q[0] <= rd_word;
        err_q[0] <= !in_range;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];
  assign rsp_err   = vld_q[RD_LAT-1] & err_q[RD_LAT-1];

endmodule

// File: tb/tb_ram_pipe.sv
// Bench for ram_pipe: two instances (256 words / latency 1, 200 words / latency 3)
// checked against a word model and a response scoreboard with due-cycle stamps.
module tb_ram_pipe;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_wr    [2];
  logic [8:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];

  logic        a_ready, a_rvalid, a_err, a_done;
  logic [31:0] a_rdata;
  logic        b_ready, b_rvalid, b_err, b_done;
  logic [31:0] b_rdata;

  ram_pipe #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .RD_LAT(1), .INIT_CLEAR(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n[0]),
    .req_valid(req_valid[0]), .req_ready(a_ready), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_done)
  );

  ram_pipe #(.DATA_W(32), .ADDR_W(9), .DEPTH(200), .RD_LAT(3), .INIT_CLEAR(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n[1]),
    .req_valid(req_valid[1]), .req_ready(b_ready), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err), .init_done(b_done)
  );

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [2][256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ncyc  = 0;

  function automatic int dep(input int d);
    return (d == 0) ? 256 : 200;
  endfunction
  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic logic f_ready(input int d);
    return (d == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic f_done(input int d);
    return (d == 0) ? a_done : b_done;
  endfunction
  function automatic logic f_rvalid(input int d);
    return (d == 0) ? a_rvalid : b_rvalid;
  endfunction
  function automatic logic f_err(input int d);
    return (d == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] f_rdata(input int d);
    return (d == 0) ? a_rdata : b_rdata;
  endfunction

  // Response monitor: every response must match the oldest pending entry of its
  // instance and arrive exactly in its due slot.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      int idx;
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].d == d) begin
          idx = i;
          break;
        end
      end
      if (f_rvalid(d)) begin
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected dut%0d: got rsp_valid=1 at cycle %0d, required 0", d, ncyc);
        end else begin
          if (f_rdata(d) !== sb[idx].data || f_err(d) !== sb[idx].err || ncyc != sb[idx].due) begin
            n_bad++;
            $display("FAIL rsp dut%0d: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                     d, f_rdata(d), f_err(d), ncyc, sb[idx].data, sb[idx].err, sb[idx].due);
          end
          sb.delete(idx);
        end
      end else begin
        n_cmp++;
        if (f_err(d) !== 1'b0) begin
          n_bad++;
          $display("FAIL rsp_err_idle dut%0d: got %b, required 0", d, f_err(d));
        end
        if (idx >= 0 && sb[idx].due <= ncyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_missing dut%0d: no response at cycle %0d, required data=%h",
                   d, ncyc, sb[idx].data);
          sb.delete(idx);
        end
      end
    end
    ncyc++;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic req(input int d, input logic wr, input logic [8:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    @(negedge clock);
    #1;
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    if (wr) begin
      if (int'(addr) < dep(d)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[d][addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end else begin
      e.d    = d;
      e.err  = !(int'(addr) < dep(d));
      e.data = e.err ? 32'h0 : mdl[d][addr[7:0]];
      e.due  = ncyc + lat(d) - 1;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input int d, input logic [8:0] addr);
    req(d, 1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic idle(input int d);
    @(negedge clock);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s drain: got %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic release_and_wait(input int d, output int cycles);
    @(negedge clock);
    reset_n[d] = 1'b1;
    cycles = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clock);
      #1;
      if (f_ready(d)) begin
        cycles = n;
        break;
      end
    end
    for (int i = 0; i < 256; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic test_reset;
    int t;
    reset_n[0] = 1'b0;
    reset_n[1] = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp += 5;
      if (f_ready(d) !== 1'b0) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b, required 0", d, f_ready(d)); end
      if (f_done(d) !== 1'b0) begin n_bad++; $display("FAIL reset_done dut%0d: got %b, required 0", d, f_done(d)); end
      if (f_rvalid(d) !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid dut%0d: got %b, required 0", d, f_rvalid(d)); end
      if (f_rdata(d) !== 32'h0) begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h, required 0", d, f_rdata(d)); end
      if (f_err(d) !== 1'b0) begin n_bad++; $display("FAIL reset_err dut%0d: got %b, required 0", d, f_err(d)); end
    end
    for (int d = 0; d < 2; d++) begin
      release_and_wait(d, t);
      n_cmp += 2;
      if (t != dep(d)) begin n_bad++; $display("FAIL init_cycles dut%0d: got %0d, required %0d", d, t, dep(d)); end
      if (f_done(d) !== 1'b1) begin n_bad++; $display("FAIL init_done dut%0d: got %b, required 1", d, f_done(d)); end
    end
    rd(0, 9'd0);
    rd(0, 9'd17);
    rd(0, 9'd255);
    idle(0);
    rd(1, 9'd0);
    rd(1, 9'd199);
    idle(1);
    wait_drain("reset_clear");
  endtask

  task automatic test_write_read;
    req(0, 1'b1, 9'd0, 32'h22450000, 4'hF);
    req(0, 1'b1, 9'd1, 32'h10F00010, 4'hF);
    rd(0, 9'd0);
    rd(0, 9'd1);
    req(0, 1'b1, 9'd2, 32'hA5A5_5A5A, 4'hF);
    rd(0, 9'd2);
    idle(0);
    wait_drain("write_read");
  endtask

  task automatic test_byte_enables;
    req(0, 1'b1, 9'd5, 32'hAABBCCDD, 4'hF);
    req(0, 1'b1, 9'd5, 32'h11223344, 4'b0101);
    rd(0, 9'd5);
    req(0, 1'b1, 9'd5, 32'hFFFFFFFF, 4'h0);
    rd(0, 9'd5);
    req(0, 1'b1, 9'd6, 32'h01234567, 4'hF);
    req(0, 1'b1, 9'd6, 32'hFEDCBA98, 4'b1010);
    rd(0, 9'd6);
    idle(0);
    wait_drain("byte_enables");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) req(1, 1'b1, 9'(i), 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) rd(1, 9'(i));
    idle(1);
    wait_drain("back_to_back");
  endtask

  task automatic test_out_of_range;
    req(1, 1'b1, 9'd199, 32'h19919919, 4'hF);
    req(1, 1'b1, 9'd44, 32'h44444444, 4'hF);
    req(1, 1'b1, 9'd300, 32'hDEADBEEF, 4'hF);
    rd(1, 9'd300);
    rd(1, 9'd199);
    rd(1, 9'd200);
    rd(1, 9'd511);
    rd(1, 9'd44);
    idle(1);
    wait_drain("out_of_range");
  endtask

  task automatic test_reset_midflight;
    int t;
    rd(1, 9'd3);
    rd(1, 9'd2);
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    reset_n[1]   = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].d == 1) sb.delete(i);
    end
    #1;
    n_cmp += 4;
    if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL midreset_rvalid: got %b, required 0", b_rvalid); end
    if (b_rdata !== 32'h0) begin n_bad++; $display("FAIL midreset_rdata: got %h, required 0", b_rdata); end
    if (b_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_ready: got %b, required 0", b_ready); end
    if (b_done !== 1'b0) begin n_bad++; $display("FAIL midreset_done: got %b, required 0", b_done); end
    repeat (4) @(negedge clock);
    release_and_wait(1, t);
    n_cmp++;
    if (t != 200) begin n_bad++; $display("FAIL midreset_init_cycles: got %0d, required 200", t); end
    rd(1, 9'd3);
    rd(1, 9'd44);
    rd(1, 9'd199);
    idle(1);
    rd(0, 9'd5);
    idle(0);
    wait_drain("reset_midflight");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_n[d]   = 1'b1;
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end
    #1;
    test_reset;
    test_write_read;
    test_byte_enables;
    test_back_to_back;
    test_out_of_range;
    test_reset_midflight;
    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
